// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters, flush FSM and stats.
// Fetch predicts from PCF; execute trains and flags redirects.
//
// Ports:
//   clk, rst (async, active-low)
//   PCF, PCPlus4F -> NextPCF, PredTakenF       fetch lookup
//   BranchE, TakenE, PCE, PCPlus4E, PCTargetE,
//   PredTakenE, PredTargetE -> MispredictE,
//   CorrectPCE                                 execute train
//   FlushReq -> FlushBusy                      table flush
//   BranchCount, MispredCount                  saturating stats
module branch_target_predictor #(
  parameter int         WORD_SIZE = 32,
  parameter int         ENTRIES   = 16,
  parameter int         INDEX_LSB = 2,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter logic [1:0] ALLOC_CTR = 2'b10,
  parameter int         CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] PCF,
  input  logic [WORD_SIZE-1:0] PCPlus4F,
  output logic [WORD_SIZE-1:0] NextPCF,
  output logic                 PredTakenF,
  input  logic                 BranchE,
  input  logic                 TakenE,
  input  logic [WORD_SIZE-1:0] PCE,
  input  logic [WORD_SIZE-1:0] PCPlus4E,
  input  logic [WORD_SIZE-1:0] PCTargetE,
  input  logic                 PredTakenE,
  input  logic [WORD_SIZE-1:0] PredTargetE,
  output logic                 MispredictE,
  output logic [WORD_SIZE-1:0] CorrectPCE,
  input  logic                 FlushReq,
  output logic                 FlushBusy,
  output logic [CNT_W-1:0]     BranchCount,
  output logic [CNT_W-1:0]     MispredCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(ENTRIES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t state, stateNext;
  logic [IDX_W-1:0] ptr, ptrNext;

  logic                 valid  [ENTRIES];
  logic [WORD_SIZE-1:0] tag    [ENTRIES];
  logic [WORD_SIZE-1:0] target [ENTRIES];
  logic [1:0]           ctr    [ENTRIES];

  logic [IDX_W-1:0] idxF, idxE;
  logic             hitF, hitE;
  logic [1:0]       ctrE, ctrInc, ctrDec;

  assign idxF = PCF[INDEX_LSB +: IDX_W];
  assign idxE = PCE[INDEX_LSB +: IDX_W];

  assign hitF = valid[idxF] && (tag[idxF] == PCF);
  assign hitE = valid[idxE] && (tag[idxE] == PCE);

  // Lines being wiped must not steer fetch.
  assign PredTakenF = hitF && ctr[idxF][1] && !FlushBusy;
  assign NextPCF    = PredTakenF ? target[idxF]
                                 : PCPlus4F;

  assign ctrE   = ctr[idxE];
  assign ctrInc = (ctrE == 2'b11) ? 2'b11
                                  : ctrE + 2'b01;
  assign ctrDec = (ctrE == 2'b00) ? 2'b00
                                  : ctrE - 2'b01;

  // A correct direction with a stale target still redirects.
  assign MispredictE = BranchE &&
    ((PredTakenE != TakenE) ||
     (TakenE && (PredTargetE != PCTargetE)));
  assign CorrectPCE = TakenE ? PCTargetE : PCPlus4E;

  assign FlushBusy = (state == FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    unique case (state)
      IDLE: begin
        if (FlushReq) begin
          stateNext = FLUSH;
          ptrNext   = '0;
        end
      end
      FLUSH: begin
        ptrNext = ptr + IDX_W'(1);
        if (ptr == LAST) stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_INIT;
      end
    end else if (state == FLUSH) begin
      valid[ptr] <= 1'b0;
      ctr[ptr]   <= CTR_INIT;
    end else if (BranchE) begin
      unique case (1'b1)
        hitE && TakenE: begin
          ctr[idxE]    <= ctrInc;
          target[idxE] <= PCTargetE;
        end
        hitE && !TakenE: begin
          ctr[idxE] <= ctrDec;
        end
        !hitE && TakenE: begin
          valid[idxE]  <= 1'b1;
          tag[idxE]    <= PCE;
          target[idxE] <= PCTargetE;
          ctr[idxE]    <= ALLOC_CTR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (BranchE && (BranchCount != '1))
        BranchCount <= BranchCount + CNT_W'(1);
      if (MispredictE && (MispredCount != '1))
        MispredCount <= MispredCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed pins plus
// random traffic checked against a table model each cycle.
module tb_branch_target_predictor;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] PCF, PCPlus4F, NextPCF;
  logic [W-1:0] PCE, PCPlus4E, PCTargetE;
  logic [W-1:0] PredTargetE, CorrectPCE;
  logic PredTakenF, BranchE, TakenE, PredTakenE;
  logic MispredictE, FlushReq, FlushBusy;
  logic [CW-1:0] BranchCount, MispredCount;

  int tests = 0;
  int fails = 0;

  bit         mValid [N];
  logic [W-1:0] mTag [N];
  logic [W-1:0] mTgt [N];
  int         mCtr   [N];
  int         flushLeft;
  int         mBr, mMis;
  bit         chkEn = 1'b0;

  always #5 clk = ~clk;

  branch_target_predictor #(
    .WORD_SIZE(W), .ENTRIES(N), .INDEX_LSB(2),
    .CTR_INIT(2'b01), .ALLOC_CTR(2'b10), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .PCF(PCF), .PCPlus4F(PCPlus4F),
    .NextPCF(NextPCF), .PredTakenF(PredTakenF),
    .BranchE(BranchE), .TakenE(TakenE),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .PCTargetE(PCTargetE),
    .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE),
    .MispredictE(MispredictE),
    .CorrectPCE(CorrectPCE),
    .FlushReq(FlushReq), .FlushBusy(FlushBusy),
    .BranchCount(BranchCount),
    .MispredCount(MispredCount)
  );

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int mIdx(input logic [W-1:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic bit mHit(input logic [W-1:0] pc);
    int i = mIdx(pc);
    return mValid[i] && (mTag[i] == pc);
  endfunction

  function automatic bit mPred();
    return mHit(PCF) && (mCtr[mIdx(PCF)] >= 2) &&
           (flushLeft == 0);
  endfunction

  function automatic logic [W-1:0] mNext();
    return mPred() ? mTgt[mIdx(PCF)] : PCPlus4F;
  endfunction

  function automatic bit mMisp();
    if (!BranchE) return 1'b0;
    if (PredTakenE != TakenE) return 1'b1;
    return TakenE && (PredTargetE != PCTargetE);
  endfunction

  task automatic mReset();
    for (int i = 0; i < N; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = '0;
      mTgt[i]   = '0;
      mCtr[i]   = 1;
    end
    flushLeft = 0;
    mBr  = 0;
    mMis = 0;
  endtask

  // Model state advance, from the spec rules.
  always @(posedge clk) begin
    if (rst) begin
      bit m;
      int i;
      m = mMisp();
      if (BranchE && mBr < CMAX) mBr++;
      if (m && mMis < CMAX) mMis++;
      if (flushLeft > 0) begin
        i = N - flushLeft;
        mValid[i] = 1'b0;
        mCtr[i]   = 1;
        flushLeft--;
      end else begin
        if (BranchE) begin
          i = mIdx(PCE);
          if (mHit(PCE)) begin
            if (TakenE) begin
              if (mCtr[i] < 3) mCtr[i]++;
              mTgt[i] = PCTargetE;
            end else if (mCtr[i] > 0) begin
              mCtr[i]--;
            end
          end else if (TakenE) begin
            mValid[i] = 1'b1;
            mTag[i]   = PCE;
            mTgt[i]   = PCTargetE;
            mCtr[i]   = 2;
          end
        end
        if (FlushReq) flushLeft = N;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    #2;
    if (chkEn) begin
      chk("NextPCF", NextPCF, mNext());
      chk("PredTakenF", W'(PredTakenF), W'(mPred()));
      chk("MispredictE", W'(MispredictE), W'(mMisp()));
      chk("CorrectPCE", CorrectPCE,
          TakenE ? PCTargetE : PCPlus4E);
      chk("FlushBusy", W'(FlushBusy),
          W'(flushLeft > 0));
      chk("BranchCount", W'(BranchCount), W'(mBr));
      chk("MispredCount", W'(MispredCount), W'(mMis));
    end
  end

  task automatic drv(input logic [W-1:0] fpc,
                     input logic br, input logic tk,
                     input logic [W-1:0] pce,
                     input logic [W-1:0] tgt,
                     input logic pt,
                     input logic [W-1:0] ptg,
                     input logic fl);
    @(negedge clk);
    PCF = fpc;
    PCPlus4F = fpc + 32'd4;
    BranchE = br;
    TakenE = tk;
    PCE = pce;
    PCPlus4E = pce + 32'd4;
    PCTargetE = tgt;
    PredTakenE = pt;
    PredTargetE = ptg;
    FlushReq = fl;
    #3;
  endtask

  task automatic idle(input logic [W-1:0] fpc);
    drv(fpc, 0, 0, '0, '0, 0, '0, 0);
  endtask

  initial begin
    int busy;
    PCF = 32'h40; PCPlus4F = 32'h44;
    BranchE = 0; TakenE = 0; PCE = '0;
    PCPlus4E = 32'h4; PCTargetE = '0;
    PredTakenE = 0; PredTargetE = '0;
    FlushReq = 0;
    mReset();
    chkEn = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pred", W'(PredTakenF), 0);
    chk("rst_next", NextPCF, 32'h44);
    chk("rst_bcnt", W'(BranchCount), 0);
    chk("rst_mcnt", W'(MispredCount), 0);
    @(negedge clk);
    rst = 1'b1;

    // Allocate on taken miss
    drv(32'h40, 1, 1, 32'h40, 32'h100, 0, 32'h44, 0);
    chk("alloc_misp", W'(MispredictE), 1);
    idle(32'h40);
    chk("alloc_next", NextPCF, 32'h100);
    chk("alloc_pred", W'(PredTakenF), 1);

    // 10 -> 01 -> 00, then saturate at 00
    drv(32'h40, 1, 0, 32'h40, 32'h0, 1, 32'h100, 0);
    drv(32'h40, 1, 0, 32'h40, 32'h0, 1, 32'h100, 0);
    idle(32'h40);
    chk("nt2_pred", W'(PredTakenF), 0);
    chk("nt2_next", NextPCF, 32'h44);
    drv(32'h40, 1, 0, 32'h40, 32'h0, 1, 32'h100, 0);
    drv(32'h40, 1, 1, 32'h40, 32'h100, 0, 32'h0, 0);
    idle(32'h40);
    chk("sat00_pred", W'(PredTakenF), 0);

    // Aliasing retag
    drv(32'h40, 1, 1, 32'h80, 32'h300, 0, 32'h0, 0);
    idle(32'h40);
    chk("alias_pred", W'(PredTakenF), 0);
    chk("alias_next", NextPCF, 32'h44);
    idle(32'h80);
    chk("alias_new", NextPCF, 32'h300);

    // Wrong target, refresh, no bypass
    drv(32'h80, 1, 1, 32'h80, 32'h200, 1, 32'h100, 0);
    chk("tgt_misp", W'(MispredictE), 1);
    chk("tgt_corr", CorrectPCE, 32'h200);
    chk("nobypass", NextPCF, 32'h300);
    idle(32'h80);
    chk("refresh", NextPCF, 32'h200);
    chk("mcnt7", W'(MispredCount), 7);
    chk("bcnt7", W'(BranchCount), 7);
    drv(32'h80, 1, 1, 32'h80, 32'h200, 1, 32'h200, 0);
    chk("good_pred", W'(MispredictE), 0);

    // Fill four lines then flush
    for (int k = 0; k < 4; k++)
      drv(32'h100 + 32'(4 * k), 1, 1,
          32'h100 + 32'(4 * k),
          32'h400 + 32'(16 * k), 0, '0, 0);
    drv(32'h10c, 0, 0, '0, '0, 0, '0, 1);
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      drv(32'h10c, c == 5, 1, 32'h100, 32'h500,
          0, '0, c == 3);
      if (c == 0)
        chk("flush_gate", W'(PredTakenF), 0);
      if (FlushBusy) busy++;
    end
    chk("flush_len", W'(busy), 16);
    for (int k = 0; k < N; k++) begin
      idle(32'h100 + 32'(4 * k));
      chk("post_flush", W'(PredTakenF), 0);
    end

    // Reset during flush
    drv(32'h0, 0, 0, '0, '0, 0, '0, 1);
    repeat (3) idle(32'h0);
    @(negedge clk);
    rst = 1'b0;
    mReset();
    #3;
    chk("rst_mid_busy", W'(FlushBusy), 0);
    chk("rst_mid_bcnt", W'(BranchCount), 0);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic; counters will saturate.
    for (int n = 0; n < 4000; n++) begin
      logic [W-1:0] fpc, pce, tgt, ptg;
      fpc = 32'($urandom_range(0, 63)) << 2;
      pce = 32'($urandom_range(0, 63)) << 2;
      tgt = 32'($urandom_range(1, 8)) << 8;
      ptg = 32'($urandom_range(1, 8)) << 8;
      drv(fpc, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), pce, tgt,
          1'($urandom_range(0, 1)), ptg,
          $urandom_range(0, 99) == 0);
    end
    chk("sat_bcnt", W'(BranchCount), CMAX);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
